// File: rtl/uio_pkg.sv
// Shared constants and state types for the bidirectional-pin input conditioner.
package uio_pkg;

    localparam int UIO_WIDTH           = 4;
    localparam int UIO_SYNC_STAGES     = 2;
    localparam int UIO_DEBOUNCE_CYCLES = 16;

    // Counter field is sized for the widest supported debounce window.
    localparam int UIO_CNT_W_MAX = 8;

    typedef struct packed {
        logic                     sync;
        logic [UIO_CNT_W_MAX-1:0] cnt;
        logic                     clean;
    } uio_deb_state_t;

endpackage

// File: rtl/uio_input_debouncer_debounce_bit.sv
// Single-bit synchroniser, stability counter and edge-pulse generator.
module debounce_bit
    import uio_pkg::*;
#(
    parameter int SYNC_STAGES     = UIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = UIO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [UIO_CNT_W_MAX-1:0] CNT_LIMIT =
        UIO_CNT_W_MAX'(CNT_LAST);

    logic [SYNC_STAGES-2:0] meta_q;
    logic [SYNC_STAGES-1:0] chain;
    uio_deb_state_t         st_q;
    uio_deb_state_t         st_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   match;
    logic                   at_limit;

    // Bit 0 is the pin, the top bit feeds the debounce stage.
    assign chain    = {meta_q, raw_in};
    assign match    = (st_q.sync == st_q.clean);
    assign at_limit = (st_q.cnt == CNT_LIMIT);

    always_comb begin
        st_d      = st_q;
        st_d.sync = chain[SYNC_STAGES-1];
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        unique case (1'b1)
            !ena: begin
                st_d.cnt = '0;
            end
            ena && match: begin
                st_d.cnt = '0;
            end
            ena && !match && at_limit: begin
                st_d.clean = st_q.sync;
                st_d.cnt   = '0;
                rise_d     = st_q.sync;
                fall_d     = !st_q.sync;
            end
            ena && !match && !at_limit: begin
                st_d.cnt = st_q.cnt + 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            st_q   <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= chain[SYNC_STAGES-2:0];
            st_q   <= st_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign clean_out  = st_q.clean;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/uio_input_debouncer.sv
// Per-bit conditioning of the raw uio pins ahead of the pin logic.
module uio_input_debouncer
    import uio_pkg::*;
#(
    parameter int WIDTH           = UIO_WIDTH,
    parameter int SYNC_STAGES     = UIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = UIO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    logic [WIDTH-1:0] clean_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .raw_in     (raw_in[i]),
            .clean_out  (clean_w[i]),
            .rise_pulse (rise_w[i]),
            .fall_pulse (fall_w[i])
        );
    end

    assign clean_out  = clean_w;
    assign rise_pulse = rise_w;
    assign fall_pulse = fall_w;

endmodule
